// File: rtl/data_mem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STATUS bit positions and the address-region encoding.
package data_mem_pkg;

  localparam logic [3:0] OFF_GPIO   = 4'h0;
  localparam logic [3:0] OFF_CYCLE  = 4'h4;
  localparam logic [3:0] OFF_TXDATA = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// Byte FIFO with extra-MSB pointers; head is combinational, push/pop take effect at the edge.
// A push into a full FIFO succeeds only when a pop happens on the same edge.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [7:0]  mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign pop_ok  = pop && !empty;
  // When full, the slot being written is the one leaving on this edge.
  assign push_ok = push && (!full || pop);
  assign head    = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-cycle data-memory responder: word RAM plus GPIO/CYCLE/TX-FIFO MMIO; reads are
// combinational, writes land at the edge; TX bytes drain by valid/ready, overflow drops and flags.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic [15:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          RW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  region_e                    region;
  logic [3:0]                 off;
  logic [31:0]                ram [RAM_WORDS];
  logic [31:0]                cycle;
  logic                       ovf;
  logic                       mmio_we;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [31:0]                status;

  always_comb begin
    region = REG_NONE;
    if (A < RAM_BYTES)                     region = REG_RAM;
    else if (A[31:4] == MMIO_BASE[31:4])   region = REG_MMIO;
  end

  assign off     = {A[3:2], 2'b00};
  assign mmio_we = WE && (region == REG_MMIO) && !clr;
  assign push    = mmio_we && (off == OFF_TXDATA);
  assign pop     = !empty && tx_ready;

  assign tx_valid = !empty;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_data (WD[7:0]),
    .pop       (pop),
    .head      (tx_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // RAM has no reset and still accepts writes while clr is high.
  always_ff @(posedge clk) begin
    if (WE && region == REG_RAM) ram[A[RW+1:2]] <= WD;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      gpio_out <= '0;
      cycle    <= '0;
      ovf      <= 1'b0;
    end else begin
      cycle <= (mmio_we && off == OFF_CYCLE) ? WD : cycle + 32'd1;
      if (mmio_we && off == OFF_GPIO) gpio_out <= WD[15:0];
      // A dropped byte sets OVF even if a clear arrives on the same edge.
      if (push && full && !pop)                     ovf <= 1'b1;
      else if (mmio_we && off == OFF_STATUS && WD[2]) ovf <= 1'b0;
    end
  end

  always_comb begin
    status                     = '0;
    status[ST_FULL]            = full;
    status[ST_EMPTY]           = empty;
    status[ST_OVF]             = ovf;
    status[ST_CNT_LSB +: 5]    = 5'(count);
  end

  always_comb begin
    RD = '0;
    case (region)
      REG_RAM:  RD = ram[A[RW+1:2]];
      REG_MMIO: begin
        case (off)
          OFF_GPIO:   RD = {16'h0000, gpio_out};
          OFF_CYCLE:  RD = cycle;
          OFF_STATUS: RD = status;
          default:    RD = '0;
        endcase
      end
      default:  RD = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios then random traffic, all checked
// against a queue/array reference model of the memory map.
module tb_data_mem_responder;

  localparam int          DEPTH = 8;
  localparam int          WORDS = 64;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic        WE = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] RD;
  logic [15:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;

  data_mem_responder #(
    .RAM_WORDS  (WORDS),
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .A        (A),
    .WD       (WD),
    .WE       (WE),
    .RD       (RD),
    .gpio_out (gpio_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit [31:0]   m_ram   [WORDS];
  bit          m_ram_v [WORDS];
  bit [15:0]   m_gpio;
  bit [31:0]   m_cycle;
  bit [7:0]    m_q [$];
  bit          m_ovf;
  bit          m_init = 1'b0;

  logic [31:0] s_rd;
  logic        s_valid;
  logic [7:0]  s_data;

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >> 4) == (BASE >> 4);
  endfunction

  function automatic bit exp_rd(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a < WORDS * 4) begin
      v = m_ram[a / 4];
      return m_ram_v[a / 4];
    end
    if (is_mmio(a)) begin
      case (a & 32'hC)
        32'h0: v = {16'h0, m_gpio};
        32'h4: v = m_cycle;
        32'h8: v = 32'h0;
        default: begin
          v    = 32'(m_q.size()) << 4;
          v[0] = (m_q.size() == DEPTH);
          v[1] = (m_q.size() == 0);
          v[2] = m_ovf;
        end
      endcase
    end
    return 1'b1;
  endfunction

  // One clock: drive at posedge+1, sample and check at the falling edge, update the model at the edge.
  task automatic step(input bit c, input logic [31:0] a, input logic [31:0] wd,
                      input bit we, input bit rdy);
    logic [31:0] e;
    bit          pop, full, mm;
    logic [31:0] o;
    clr = c; A = a; WD = wd; WE = we; tx_ready = rdy;
    #4;
    s_rd = RD; s_valid = tx_valid; s_data = tx_data;
    if (m_init) begin
      if (exp_rd(a, e)) check_eq("rd", RD, e);
      check_eq("gpio_out", {16'h0, gpio_out}, {16'h0, m_gpio});
      check_eq("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
      check_eq("tx_data", {24'h0, tx_data}, (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
    end
    @(posedge clk);
    if (we && a < WORDS * 4) begin
      m_ram[a / 4]   = wd;
      m_ram_v[a / 4] = 1'b1;
    end
    if (c) begin
      m_gpio = '0; m_cycle = '0; m_ovf = 1'b0; m_q.delete(); m_init = 1'b1;
    end else begin
      pop  = (m_q.size() > 0) && rdy;
      full = (m_q.size() == DEPTH);
      mm   = we && is_mmio(a);
      o    = a & 32'hC;
      m_cycle = (mm && o == 32'h4) ? wd : m_cycle + 32'd1;
      if (mm && o == 32'h0) m_gpio = wd[15:0];
      if (pop) void'(m_q.pop_front());
      if (mm && o == 32'h8) begin
        if (!full || pop) m_q.push_back(wd[7:0]);
        else              m_ovf = 1'b1;
      end else if (mm && o == 32'hC && wd[2]) begin
        m_ovf = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    logic [7:0]  last;

    step(1, 32'h0, 32'h0, 0, 0);

    // RAM and unmapped
    step(0, 32'h10, 32'hDEAD_BEEF, 1, 0);
    step(0, 32'h10, 32'h0, 0, 0);      check_eq("ram_rd", s_rd, 32'hDEAD_BEEF);
    step(0, 32'h13, 32'h0, 0, 0);      check_eq("ram_rd_unaligned", s_rd, 32'hDEAD_BEEF);
    step(0, 32'h1000, 32'h0, 0, 0);    check_eq("unmapped_rd", s_rd, 32'h0);
    step(0, 32'h1000, 32'h5555_5555, 1, 0);

    // GPIO and CYCLE
    step(0, BASE, 32'h0, 0, 0);        check_eq("gpio_reset", s_rd, 32'h0);
    step(0, BASE, 32'h1234_ABCD, 1, 0);
    step(0, BASE, 32'h0, 0, 0);
    check_eq("gpio_rd", s_rd, 32'h0000_ABCD);
    check_eq("gpio_out_val", {16'h0, gpio_out}, 32'h0000_ABCD);
    step(0, BASE + 4, 32'hFFFF_FFFE, 1, 0);
    step(0, BASE + 4, 32'h0, 0, 0);    check_eq("cycle_load", s_rd, 32'hFFFF_FFFE);
    step(0, BASE + 4, 32'h0, 0, 0);    check_eq("cycle_inc", s_rd, 32'hFFFF_FFFF);
    step(0, BASE + 4, 32'h0, 0, 0);    check_eq("cycle_wrap", s_rd, 32'h0);

    // FIFO fill, overflow, clear
    for (int i = 0; i < 8; i++) step(0, BASE + 8, 32'h41 + i, 1, 0);
    step(0, BASE + 12, 32'h0, 0, 0);   check_eq("status_full", s_rd, 32'h81);
    step(0, BASE + 8, 32'h49, 1, 0);
    step(0, BASE + 12, 32'h0, 0, 0);   check_eq("status_ovf", s_rd, 32'h85);
    step(0, BASE + 8, 32'h4A, 1, 0);
    step(0, BASE + 12, 32'h0, 0, 0);   check_eq("ovf_sticky", s_rd, 32'h85);
    step(0, BASE + 12, 32'h4, 1, 0);
    step(0, BASE + 12, 32'h0, 0, 0);   check_eq("ovf_clear", s_rd, 32'h81);
    step(0, BASE + 8, 32'h0, 0, 0);    check_eq("txdata_rd", s_rd, 32'h0);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      step(0, BASE + 12, 32'h0, 0, 1);
      check_eq("drain_valid", {31'h0, s_valid}, 32'h1);
      check_eq("drain_byte", {24'h0, s_data}, 32'h41 + i);
    end
    step(0, BASE + 12, 32'h0, 0, 1);
    check_eq("drained_valid", {31'h0, s_valid}, 32'h0);
    check_eq("drained_status", s_rd, 32'h02);

    // Push and pop together on a full FIFO
    for (int i = 0; i < 8; i++) step(0, BASE + 8, 32'h41 + i, 1, 0);
    step(0, BASE + 8, 32'h55, 1, 1);
    step(0, BASE + 12, 32'h0, 0, 0);   check_eq("full_pushpop", s_rd, 32'h81);
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(0, BASE + 12, 32'h0, 0, 1);
      last = s_data;
    end
    check_eq("eighth_byte", {24'h0, last}, 32'h55);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(0, BASE + 8, 32'h61 + i, 1, 0);
    step(0, BASE + 12, 32'h0, 0, 1);
    step(1, BASE + 8, 32'h77, 1, 1);
    step(0, BASE + 4, 32'h0, 0, 0);
    check_eq("rst_cycle", s_rd, 32'h0);
    check_eq("rst_valid", {31'h0, s_valid}, 32'h0);
    check_eq("rst_data", {24'h0, s_data}, 32'h0);
    step(0, BASE + 12, 32'h0, 0, 0);   check_eq("rst_status", s_rd, 32'h02);
    step(0, 32'h10, 32'h0, 0, 0);      check_eq("rst_ram_keep", s_rd, 32'hDEAD_BEEF);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3)      a = $urandom_range(0, WORDS * 4 - 1);
      else if (kind < 9) a = BASE + $urandom_range(0, 15);
      else               a = 32'h0000_1000 | ($urandom & 32'h0FFF_FFFF);
      step(($urandom_range(0, 60) == 0), a, $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
